// File: rtl/wb_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and the STATUS word builder
// for the Wishbone mailbox FIFO.
package wb_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_UNF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  function automatic logic [31:0] status_word(input logic       empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic       unf,
                                              input logic [7:0] cnt);
    logic [31:0] w;
    w                      = '0;
    w[STAT_EMPTY]          = empty;
    w[STAT_FULL]           = full;
    w[STAT_OVF]            = ovf;
    w[STAT_UNF]            = unf;
    w[STAT_CNT_LSB +: 8]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with array storage and a registered read port; a pop
// loads rd_data at the popping edge, pushes to a full FIFO are discarded.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_reg;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign count   = count_reg;
  assign rd_data = rd_data_reg;

  always_comb begin
    count_next = count_reg;
    if (flush)        count_next = '0;
    else if (do_push) count_next = count_reg + CW'(1);
    else if (do_pop)  count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
    if (do_pop)  rd_data_reg     <= mem[rd_ptr_reg];
  end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone classic responder exposing a mailbox FIFO through DATA, STATUS,
// CTRL and THRESH registers, with a level-threshold interrupt.
module wb_fifo_slave
  import wb_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  input  logic          we_i,
  input  logic [3:0]    sel_i,
  input  logic          stb_i,
  input  logic          cyc_i,
  output logic          ack_o,
  output logic          irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          ack_reg, pop_sel_reg, ovf_reg, unf_reg, irq_reg;
  logic [DW-1:0] rdata_reg;
  logic [7:0]    thresh_reg;

  logic          pop_sel_next, ovf_next, unf_next, irq_next;
  logic [DW-1:0] rdata_next;
  logic [7:0]    thresh_next;

  logic          accept;
  logic [1:0]    reg_sel;
  logic          fifo_push, fifo_pop, fifo_flush, flag_clear, thresh_wr;
  logic [DW-1:0] fifo_rd_data;
  logic [CW-1:0] fifo_count, fifo_count_next;
  logic          fifo_full, fifo_empty;
  logic          unused_adr;

  assign unused_adr = ^{adr_i[AW-1:4], adr_i[1:0]};

  assign accept     = cyc_i & stb_i & ~ack_reg;
  assign reg_sel    = adr_i[3:2];
  assign fifo_push  = accept & we_i & (reg_sel == REG_DATA) & (sel_i == 4'hF);
  assign fifo_pop   = accept & ~we_i & (reg_sel == REG_DATA);
  assign fifo_flush = accept & we_i & (reg_sel == REG_CTRL) & sel_i[0] & dat_i[CTRL_FLUSH];
  assign flag_clear = accept & we_i & (reg_sel == REG_CTRL) & sel_i[0] & dat_i[CTRL_CLR];
  assign thresh_wr  = accept & we_i & (reg_sel == REG_THRESH) & sel_i[0];

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .wr_data    (dat_i),
    .rd_data    (fifo_rd_data),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    ovf_next     = ovf_reg;
    unf_next     = unf_reg;
    thresh_next  = thresh_reg;
    rdata_next   = '0;
    pop_sel_next = fifo_pop & ~fifo_empty;
    if (flag_clear) begin
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end
    if (fifo_push && fifo_full)  ovf_next = 1'b1;
    if (fifo_pop && fifo_empty)  unf_next = 1'b1;
    if (thresh_wr)               thresh_next = dat_i[7:0];
    // Non-DATA reads are captured here; popped data comes from the FIFO port.
    if (accept && !we_i) begin
      case (reg_sel)
        REG_STATUS: rdata_next = DW'(status_word(fifo_empty, fifo_full, ovf_reg, unf_reg,
                                                 8'(fifo_count)));
        REG_THRESH: rdata_next = DW'(thresh_reg);
        default:    rdata_next = '0;
      endcase
    end
    irq_next = (thresh_next != 8'd0) && (8'(fifo_count_next) >= thresh_next);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_reg     <= 1'b0;
      pop_sel_reg <= 1'b0;
      rdata_reg   <= '0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
      thresh_reg  <= '0;
      irq_reg     <= 1'b0;
    end else begin
      ack_reg     <= accept;
      pop_sel_reg <= pop_sel_next;
      rdata_reg   <= rdata_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
      thresh_reg  <= thresh_next;
      irq_reg     <= irq_next;
    end
  end

  assign ack_o = ack_reg;
  assign irq_o = irq_reg;
  assign dat_o = !ack_reg ? '0 : (pop_sel_reg ? fifo_rd_data : rdata_reg);

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Randomized and directed bench for wb_fifo_slave: a queue-based mailbox model
// predicts each response, and a monitor checks every ack against it.
module tb_wb_fifo_slave;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        ack_o;
  logic        irq_o;

  wb_fifo_slave #(.DEPTH(DEPTH), .DW(32), .AW(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .we_i   (we_i),
    .sel_i  (sel_i),
    .stb_i  (stb_i),
    .cyc_i  (cyc_i),
    .ack_o  (ack_o),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        chk_dat;
    logic [31:0] dat;
    logic        irq;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mbox[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [7:0]  m_thresh = 8'd0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Mailbox behaviour: each accepted access applied to the model, the
  // response it should produce queued for the monitor.
  function automatic void model_access(input bit we, input logic [1:0] r,
                                       input logic [31:0] data, input logic [3:0] sel);
    exp_t e;
    e.chk_dat = !we;
    e.dat     = 32'h0;
    case (r)
      2'd0: begin
        if (we) begin
          if (sel == 4'hF) begin
            if (mbox.size() < DEPTH) mbox.push_back(data);
            else m_ovf = 1'b1;
          end
        end else if (mbox.size() == 0) begin
          m_unf = 1'b1;
        end else begin
          e.dat = mbox.pop_front();
        end
      end
      2'd1: if (!we) e.dat = {16'h0, 8'(mbox.size()), 4'h0, m_unf, m_ovf,
                              mbox.size() == DEPTH, mbox.size() == 0};
      2'd2: if (we && sel[0]) begin
        if (data[1]) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        if (data[0]) mbox.delete();
      end
      default: begin
        if (we && sel[0]) m_thresh = data[7:0];
        else if (!we)     e.dat = {24'h0, m_thresh};
      end
    endcase
    e.irq = (m_thresh != 0) && (mbox.size() >= int'(m_thresh));
    exp_q.push_back(e);
  endfunction

  task automatic drive(input bit we, input logic [1:0] r, input logic [31:0] data,
                       input logic [3:0] sel);
    logic [31:0] a;
    a      = $urandom;
    a[3:2] = r;
    adr_i  = a;
    we_i   = we;
    dat_i  = data;
    sel_i  = sel;
    cyc_i  = 1'b1;
    stb_i  = 1'b1;
  endtask

  task automatic idle_bus();
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic wb(input bit we, input logic [1:0] r, input logic [31:0] data,
                    input logic [3:0] sel);
    @(negedge clk_i);
    model_access(we, r, data, sel);
    drive(we, r, data, sel);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (ack_o) break;
    end
    check("ack_seen", {31'h0, ack_o}, 32'h1);
    idle_bus();
  endtask

  task automatic model_reset();
    mbox.delete();
    exp_q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_thresh = 8'd0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_ack <= 1'b0;
    end else begin
      if (ack_o) begin
        exp_t e;
        check("ack_pulse", {31'h0, prev_ack}, 32'h0);
        check("ack_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.chk_dat) check("rd_data", dat_o, e.dat);
          check("irq", {31'h0, irq_o}, {31'h0, e.irq});
        end
      end else begin
        check("dat_idle_zero", dat_o, 32'h0);
      end
      prev_ack <= ack_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_ack", {31'h0, ack_o}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    rst_ni = 1'b1;

    wb(0, 2'd1, 0, 4'hF);
    wb(1, 2'd0, 32'hA5A5_0001, 4'hF);
    wb(1, 2'd0, 32'hA5A5_0002, 4'hF);
    wb(0, 2'd0, 0, 4'hF);
    wb(0, 2'd0, 0, 4'hF);
    wb(0, 2'd1, 0, 4'hF);

    for (int i = 1; i <= 9; i++) wb(1, 2'd0, 32'(i), 4'hF);
    wb(0, 2'd1, 0, 4'hF);
    for (int i = 0; i < 8; i++) wb(0, 2'd0, 0, 4'hF);
    wb(0, 2'd0, 0, 4'hF);
    wb(0, 2'd1, 0, 4'hF);
    wb(1, 2'd2, 32'h2, 4'h1);
    wb(0, 2'd1, 0, 4'hF);

    wb(1, 2'd3, 32'h3, 4'h1);
    for (int i = 0; i < 3; i++) wb(1, 2'd0, 32'hB000_0000 + 32'(i), 4'hF);
    wb(0, 2'd0, 0, 4'hF);
    wb(0, 2'd3, 0, 4'hF);
    wb(1, 2'd0, 32'hDEAD_BEEF, 4'h3);
    wb(1, 2'd1, 32'hFFFF_FFFF, 4'hF);
    wb(0, 2'd2, 0, 4'hF);
    wb(0, 2'd1, 0, 4'hF);

    // Flush while full keeps OVF; flush+clear together drops both.
    for (int i = 0; i < 9; i++) wb(1, 2'd0, 32'hC000_0000 + 32'(i), 4'hF);
    wb(1, 2'd2, 32'h1, 4'h1);
    wb(0, 2'd1, 0, 4'hF);
    wb(1, 2'd0, 32'h1234_5678, 4'hF);
    wb(1, 2'd2, 32'h3, 4'h1);
    wb(0, 2'd1, 0, 4'hF);

    // Strobe held for four cycles: two accepts, ack every other cycle.
    @(negedge clk_i);
    model_access(1, 2'd0, 32'hC0DE_0001, 4'hF);
    model_access(1, 2'd0, 32'hC0DE_0001, 4'hF);
    drive(1, 2'd0, 32'hC0DE_0001, 4'hF);
    check("hold_ack_c0", {31'h0, ack_o}, 32'h0);
    @(negedge clk_i);
    check("hold_ack_c1", {31'h0, ack_o}, 32'h1);
    @(negedge clk_i);
    check("hold_ack_c2", {31'h0, ack_o}, 32'h0);
    @(negedge clk_i);
    check("hold_ack_c3", {31'h0, ack_o}, 32'h1);
    idle_bus();
    wb(0, 2'd1, 0, 4'hF);
    wb(0, 2'd0, 0, 4'hF);
    wb(0, 2'd0, 0, 4'hF);

    // Reset asserted in the middle of an ack cycle.
    wb(1, 2'd3, 32'h1, 4'h1);
    @(negedge clk_i);
    model_access(1, 2'd0, 32'h0BAD_F00D, 4'hF);
    drive(1, 2'd0, 32'h0BAD_F00D, 4'hF);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_ack", {31'h0, ack_o}, 32'h0);
    check("rst_mid_dat", dat_o, 32'h0);
    check("rst_mid_irq", {31'h0, irq_o}, 32'h0);
    model_reset();
    idle_bus();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    wb(0, 2'd1, 0, 4'hF);

    for (int n = 0; n < 400; n++) begin
      logic [1:0]  r;
      bit          we;
      logic [31:0] d;
      logic [3:0]  s;
      r = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      s = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      if (r == 2'd3) d[7:0] = 8'($urandom_range(0, DEPTH + 1));
      if (r == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      wb(we, r, d, s);
    end

    repeat (3) @(negedge clk_i);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_fifo_slave.md
Name: wb_fifo_slave

Overview:
Wishbone classic responder that sits on a slave port of wbInterconnect. It exposes a word-wide mailbox FIFO through four 32-bit registers. Masters push by writing DATA and pop by reading DATA. Status, control and a level-threshold interrupt let a consumer master poll the FIFO or take an interrupt.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..128.
DW, 32, data width; fixed at 32 for this revision.
AW, 32, address width; only adr_i[3:2] is decoded, the interconnect has already selected this slave.

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_ni  in  1  asynchronous active-low reset.
adr_i  in  AW  byte address; [3:2] selects the register.
dat_i  in  DW  write data.
dat_o  out  DW  read data, valid while ack_o=1.
we_i  in  1  1 = write, 0 = read.
sel_i  in  4  byte selects.
stb_i  in  1  strobe.
cyc_i  in  1  bus cycle.
ack_o  out  1  acknowledge, one-cycle pulse.
irq_o  out  1  level interrupt: count >= THRESH and THRESH != 0.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - ack_o=0, dat_o=0, irq_o=0.
  - FIFO empty, pointers 0, count 0.
  - THRESH=0, sticky flags 0.
  - A transaction in flight is abandoned; no ack follows reset release.
- Access acceptance:
  - A request is accepted at an edge where cyc_i & stb_i & !ack_o.
  - ack_o is 1 for exactly the next cycle, then 0. Single-cycle latency, so back-to-back strobes are acked every other cycle.
  - All side effects (push, pop, flags, CTRL, THRESH) commit at the accepting edge.
  - dat_o is registered at that same edge.
  - dat_o=0 when ack_o=0.
  - Dropping stb_i/cyc_i after acceptance does not cancel the ack or the side effect.
- Register map, word offset = adr_i[3:2]:
  - 0 DATA.
    - Write with sel_i=4'hF pushes dat_i. If the FIFO is full, the data is dropped and OVF is set. A write with any other sel_i is acked but ignored.
    - Read pops the head into dat_o. If the FIFO is empty, dat_o=0 and UNF is set.
  - 1 STATUS, read-only; writes are acked and ignored.
    - [0] EMPTY, [1] FULL, [2] OVF sticky, [3] UNF sticky.
    - [15:8] count, zero-extended. Other bits 0.
  - 2 CTRL, write-only; reads return 0.
    - Write with sel_i[0] set: bit0=1 flushes (count=0, pointers=0); bit1=1 clears OVF and UNF.
    - Both bits may be set together.
  - 3 THRESH, read/write.
    - Bits [7:0] are written when sel_i[0]=1. Reads return the value zero-extended.
- Count is $clog2(DEPTH)+1 bits, with range 0..DEPTH.
  - FULL = (count==DEPTH). EMPTY = (count==0).
  - Pointers wrap modulo DEPTH.
- irq_o is registered: it reflects count and THRESH after the accepting edge and is valid in the ack cycle.
- Simultaneous events: a single port means push and pop cannot coincide. Flush plus clear in one write applies both. A flush while full clears FULL; OVF stays set unless bit1 is also set.

Decomposition:
- Package wb_fifo_pkg holds:
  - register offset constants REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_THRESH=2'd3;
  - STATUS bit index constants;
  - CTRL bit index constants.
- Sub-module sync_fifo (DEPTH, DW) contains:
  - push/pop/flush inputs;
  - registered rd_data;
  - count, full and empty outputs.
- The Wishbone decode, sticky flags, THRESH and irq stay in wb_fifo_slave.

Test Plan:
- Reset, then read STATUS → ack one cycle after stb, dat_o=32'h0000_0001 (EMPTY, count 0); irq_o=0.
- Write DATA 32'hA5A5_0001, 32'hA5A5_0002, then read DATA twice → returns 32'hA5A5_0001 then 32'hA5A5_0002. STATUS afterwards = 32'h1.
- With DEPTH=8, push 9 words 1..9 → STATUS=32'h0000_0806 (count 8, FULL, OVF). Popping 8 words returns 1..8.
- Read DATA when empty → dat_o=0, STATUS bit3 set. Write CTRL=2 → STATUS back to 32'h1.
- Write THRESH=3, push 3 words → irq_o rises in the ack cycle of the third push. Pop one → irq_o=0.
- Hold stb_i/cyc_i for 4 cycles on a DATA write → ack pattern 0,1,0,1 with 2 pushes. Assert rst_ni=0 while ack_o=1 → ack_o=0 immediately, count 0.
